fpadd_arbiter: RTL and testbench

FPADD_ARBITER -- requirements
Module: fpadd_arbiter

---
 rtl/fpadd_arbiter.sv | 172 +++++++++++++++++
 tb/tb_fpadd_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpadd_arbiter.sv
// fpadd_arbiter: four requesters share one FP adder through a round-robin
// arbiter. Each request runs IDLE -> ISSUE -> WAIT -> RESP, and only one
// operation is outstanding at a time. Every output comes straight from a flop.
// Defining FPADD_ARB_TIMEOUT_EN adds a WAIT-state watchdog. When it fires,
// the response is a quiet NaN with rsp_err set.
module fpadd_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 63
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [3:0]   req,
   input  logic [127:0] req_a,
   input  logic [127:0] req_b,
   output logic [3:0]   gnt,
   output logic [3:0]   rsp_valid,
   output logic [31:0]  rsp_sum,
   output logic         rsp_err,
   output logic         busy,
   output logic         add_start,
   output logic [31:0]  add_a,
   output logic [31:0]  add_b,
   input  logic [31:0]  add_sum,
   input  logic         add_done
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t      state_q, state_d;
   logic [1:0]  ptr_q, ptr_d;
   logic [1:0]  owner_q, owner_d;
   logic [3:0]  gnt_q, gnt_d;
   logic [3:0]  rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_sum_q, rsp_sum_d;
   logic        rsp_err_q, rsp_err_d;
   logic        busy_q, busy_d;
   logic        add_start_q, add_start_d;
   logic [31:0] add_a_q, add_a_d;
   logic [31:0] add_b_q, add_b_d;

`ifdef FPADD_ARB_TIMEOUT_EN
   // The watchdog is 8 bits wide, so TIMEOUT_CYCLES is taken modulo 256.
   localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);
   logic [7:0] wdog_q, wdog_d;
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

   logic       pick_found;
   logic [1:0] pick_idx;

   // Round-robin pick: take the first requester at or after ptr, wrapping mod 4
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = ptr_q;
      for (int unsigned i = 0; i < 4; i++) begin
         if (!pick_found && req[ptr_q + 2'(i)]) begin
            pick_found = 1'b1;
            pick_idx   = ptr_q + 2'(i);
         end
      end
   end

   // Next-state logic and the next value of every registered output
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      gnt_d       = gnt_q;
      rsp_valid_d = rsp_valid_q;
      rsp_sum_d   = rsp_sum_q;
      rsp_err_d   = rsp_err_q;
      add_start_d = add_start_q;
      add_a_d     = add_a_q;
      add_b_d     = add_b_q;
`ifdef FPADD_ARB_TIMEOUT_EN
      wdog_d      = wdog_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (pick_found) begin
               owner_d     = pick_idx;
               add_a_d     = req_a[{pick_idx, 5'd0} +: 32];
               add_b_d     = req_b[{pick_idx, 5'd0} +: 32];
               gnt_d       = 4'b0001 << pick_idx;
               add_start_d = 1'b1;
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            // add_done may still be high from the previous operation, so it is ignored here
            gnt_d       = '0;
            add_start_d = 1'b0;
`ifdef FPADD_ARB_TIMEOUT_EN
            wdog_d      = '0;
`endif
            state_d     = WAIT;
         end
         WAIT: begin
            if (add_done) begin
               rsp_sum_d   = add_sum;
               rsp_err_d   = 1'b0;
               rsp_valid_d = 4'b0001 << owner_q;
               state_d     = RESP;
            end
`ifdef FPADD_ARB_TIMEOUT_EN
            else begin
               wdog_d = wdog_q + 8'd1;
               if (wdog_d == TMO) begin
                  rsp_sum_d   = 32'h7FC0_0000;
                  rsp_err_d   = 1'b1;
                  rsp_valid_d = 4'b0001 << owner_q;
                  state_d     = RESP;
               end
            end
`endif
         end
         RESP: begin
            rsp_valid_d = '0;
            ptr_d       = owner_q + 2'd1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and output registers, cleared asynchronously by reset_n
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         owner_q     <= '0;
         gnt_q       <= '0;
         rsp_valid_q <= '0;
         rsp_sum_q   <= '0;
         rsp_err_q   <= 1'b0;
         busy_q      <= 1'b0;
         add_start_q <= 1'b0;
         add_a_q     <= '0;
         add_b_q     <= '0;
`ifdef FPADD_ARB_TIMEOUT_EN
         wdog_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         owner_q     <= owner_d;
         gnt_q       <= gnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_sum_q   <= rsp_sum_d;
         rsp_err_q   <= rsp_err_d;
         busy_q      <= busy_d;
         add_start_q <= add_start_d;
         add_a_q     <= add_a_d;
         add_b_q     <= add_b_d;
`ifdef FPADD_ARB_TIMEOUT_EN
         wdog_q      <= wdog_d;
`endif
      end
   end

   assign gnt       = gnt_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_sum   = rsp_sum_q;
   assign rsp_err   = rsp_err_q;
   assign busy      = busy_q;
   assign add_start = add_start_q;
   assign add_a     = add_a_q;
   assign add_b     = add_b_q;

endmodule

// File: tb/tb_fpadd_arbiter.sv
// tb_fpadd_arbiter: random requesters and a behavioural adder model drive
// fpadd_arbiter. A transaction-level reference tracks each grant, response
// and ptr value and checks them against the DUT.
`timescale 1ns/1ps
module tb_fpadd_arbiter;

   localparam int unsigned TMO = 63;

   logic         clk = 1'b0;
   logic         reset_n;
   logic [3:0]   req;
   logic [127:0] req_a, req_b;
   logic [3:0]   gnt, rsp_valid;
   logic [31:0]  rsp_sum, add_a, add_b, add_sum;
   logic         rsp_err, busy, add_start, add_done;

   always #5 clk = ~clk;

   fpadd_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .req_a(req_a), .req_b(req_b),
      .gnt(gnt), .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .rsp_err(rsp_err),
      .busy(busy), .add_start(add_start), .add_a(add_a), .add_b(add_b),
      .add_sum(add_sum), .add_done(add_done)
   );

   int unsigned checks = 0;
   int unsigned errors = 0;

   // Reference state: pending requests, operands, round-robin pointer, skip counts
   logic [3:0]   pend;
   logic [31:0]  op_a [4];
   logic [31:0]  op_b [4];
   int unsigned  skips [4];
   int unsigned  mptr;
   logic [31:0]  last_sum;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   // First pending requester, scanning p, p+1, ... mod 4
   function automatic int unsigned rr_pick(input logic [3:0] m, input int unsigned p);
      for (int unsigned k = 0; k < 4; k++)
         if (m[(p + k) % 4]) return (p + k) % 4;
      return 0;
   endfunction

   // Adder stand-in: the one real sum used by the bench, otherwise a scrambled value
   function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
      return {a[31:16] ^ b[15:0], a[15:0] + b[31:16]};
   endfunction

   task automatic drive();
      req = pend;
      for (int unsigned i = 0; i < 4; i++) begin
         req_a[i*32 +: 32] = op_a[i];
         req_b[i*32 +: 32] = op_b[i];
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_gnt"}, gnt, 0);
      chk({tag, "_rsp_valid"}, rsp_valid, 0);
      chk({tag, "_rsp_sum"}, rsp_sum, 0);
      chk({tag, "_rsp_err"}, rsp_err, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_add_start"}, add_start, 0);
      chk({tag, "_add_a"}, add_a, 0);
      chk({tag, "_add_b"}, add_b, 0);
   endtask

   // Entered at posedge+1 while the DUT is in IDLE; leaves it one cycle into WAIT
   task automatic issue(input logic [3:0] add_mask, input bit stale,
                        output int unsigned idx, output logic [31:0] ea,
                        output logic [31:0] eb, output logic [3:0] g);
      for (int unsigned i = 0; i < 4; i++)
         if (add_mask[i] && !pend[i]) begin
            pend[i]  = 1'b1;
            op_a[i]  = $urandom;
            op_b[i]  = $urandom;
            skips[i] = 0;
         end
      drive();
      add_done = stale;
      idx = rr_pick(pend, mptr);
      ea  = op_a[idx];
      eb  = op_b[idx];
      @(posedge clk); #1;
      g = gnt;
      chk("gnt", gnt, 32'd1 << idx);
      chk("add_start", add_start, 1);
      chk("busy_issue", busy, 1);
      chk("add_a", add_a, ea);
      chk("add_b", add_b, eb);
      for (int unsigned j = 0; j < 4; j++)
         if (pend[j]) begin
            if (g[j]) skips[j] = 0;
            else begin
               skips[j]++;
               chk("fairness", 32'(skips[j] <= 3), 1);
            end
         end
      pend[idx] = 1'b0;
      drive();
      @(posedge clk); #1;
      chk("gnt_pulse", gnt, 0);
      chk("start_pulse", add_start, 0);
      chk("stale_done_ignored", rsp_valid, 0);
      chk("busy_wait", busy, 1);
      add_done = 1'b0;
   endtask

   // Holds add_done low for delay more WAIT cycles, then completes the operation
   task automatic finish_op(input int unsigned idx, input logic [31:0] ea,
                            input logic [31:0] eb, input int unsigned delay);
      logic [31:0] s;
      repeat (delay) begin
         @(posedge clk); #1;
         chk("no_early_rsp", rsp_valid, 0);
         chk("busy_wait", busy, 1);
      end
      s = fp_model(ea, eb);
      add_sum  = s;
      add_done = 1'b1;
      @(posedge clk); #1;
      chk("rsp_valid", rsp_valid, 32'd1 << idx);
      chk("rsp_sum", rsp_sum, s);
      chk("rsp_err", rsp_err, 0);
      chk("busy_resp", busy, 1);
      @(posedge clk); #1;
      chk("rsp_pulse", rsp_valid, 0);
      chk("busy_idle", busy, 0);
      chk("rsp_sum_hold", rsp_sum, s);
      chk("add_a_hold", add_a, ea);
      last_sum = s;
      mptr = (idx + 1) % 4;
   endtask

   task automatic idle_gap(input int unsigned n);
      repeat (n) begin
         @(posedge clk); #1;
         chk("idle_busy", busy, 0);
         chk("idle_gnt", gnt, 0);
         chk("idle_start", add_start, 0);
         chk("idle_sum_hold", rsp_sum, last_sum);
      end
   endtask

   // Asserts reset_n mid-cycle; the outputs must clear before any clock edge
   task automatic do_reset(input string tag);
      reset_n = 1'b0;
      #1;
      check_zero(tag);
      pend = '0;
      drive();
      add_done = 1'b0;
      @(posedge clk); #1;
      check_zero({tag, "_held"});
      reset_n  = 1'b1;
      mptr     = 0;
      last_sum = '0;
      for (int unsigned i = 0; i < 4; i++) skips[i] = 0;
   endtask

   initial begin
      int unsigned idx;
      logic [31:0] ea, eb;
      logic [3:0]  g;
      bit          stale;

      reset_n = 1'b0; add_sum = '0; add_done = 1'b0;
      pend = '0; mptr = 0; last_sum = '0;
      for (int unsigned i = 0; i < 4; i++) begin op_a[i] = '0; op_b[i] = '0; skips[i] = 0; end
      drive();
      #2;
      check_zero("reset");
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset_clk");
      reset_n = 1'b1;
      idle_gap(2);

      // 1.0 + 2.0 from requester 1; add_done arrives in cycle 5
      op_a[1] = 32'h3F80_0000; op_b[1] = 32'h4000_0000; pend[1] = 1'b1;
      issue(4'b0000, 1'b0, idx, ea, eb, g);
      chk("basic_gnt", g, 4'b0010);
      finish_op(idx, ea, eb, 3);
      chk("basic_sum", rsp_sum, 32'h4040_0000);
      idle_gap(1);

      // All four requesting right after reset: grants go 0,1,2,3
      do_reset("reset_mid");
      for (int unsigned k = 0; k < 4; k++) begin
         issue(k == 0 ? 4'b1111 : 4'b0000, 1'b0, idx, ea, eb, g);
         chk("order", g, 32'd1 << k);
         finish_op(idx, ea, eb, k);
      end

      // Last owner was 3, so ptr has wrapped to 0
      issue(4'b1001, 1'b0, idx, ea, eb, g);
      chk("wrap_first", g, 4'b0001);
      finish_op(idx, ea, eb, 1);
      issue(4'b0000, 1'b0, idx, ea, eb, g);
      chk("wrap_second", g, 4'b1000);
      finish_op(idx, ea, eb, 2);

      // add_done still high from the previous op through ISSUE, then dropped and raised 4 cycles later
      issue(4'b0100, 1'b1, idx, ea, eb, g);
      finish_op(idx, ea, eb, 4);

      // Random mix of requests, adder latencies and stale done levels
      for (int unsigned n = 0; n < 40; n++) begin
         if (pend == 0) idle_gap($urandom_range(0, 2));
         stale = 1'($urandom_range(0, 1));
         issue(pend == 0 ? 4'($urandom_range(1, 15)) : 4'($urandom_range(0, 15)),
               stale, idx, ea, eb, g);
         finish_op(idx, ea, eb, $urandom_range(stale ? 1 : 0, 6));
      end
      while (pend != 0) begin
         issue(4'b0000, 1'b0, idx, ea, eb, g);
         finish_op(idx, ea, eb, 0);
      end

`ifdef FPADD_ARB_TIMEOUT_EN
      // Watchdog fires after TMO WAIT cycles without add_done
      issue(4'b0010, 1'b0, idx, ea, eb, g);
      repeat (TMO - 1) begin
         @(posedge clk); #1;
         chk("wdog_no_early", rsp_valid, 0);
      end
      @(posedge clk); #1;
      chk("wdog_rsp_valid", rsp_valid, 32'd1 << idx);
      chk("wdog_rsp_sum", rsp_sum, 32'h7FC0_0000);
      chk("wdog_rsp_err", rsp_err, 1);
      @(posedge clk); #1;
      chk("wdog_rsp_pulse", rsp_valid, 0);
      chk("wdog_busy_idle", busy, 0);
      mptr = (idx + 1) % 4;
      // add_done in the same cycle the watchdog expires: add_done wins
      issue(4'b0001, 1'b0, idx, ea, eb, g);
      finish_op(idx, ea, eb, TMO - 1);
      issue(4'b1000, 1'b0, idx, ea, eb, g);
      repeat (5) @(posedge clk);
      #1;
`else
      // No watchdog: the operation waits forever
      issue(4'b0010, 1'b0, idx, ea, eb, g);
      repeat (100) begin
         @(posedge clk); #1;
         chk("hang_busy", busy, 1);
         chk("hang_no_rsp", rsp_valid, 0);
      end
`endif

      // Reset in mid-WAIT abandons the op; the next grant arbitrates from ptr 0 with a fresh start
      do_reset("reset_wait");
      issue(4'b0100, 1'b0, idx, ea, eb, g);
      chk("post_reset_gnt", g, 4'b0100);
      finish_op(idx, ea, eb, 2);
      issue(4'b0110, 1'b0, idx, ea, eb, g);
      chk("post_reset_rr", g, 4'b0010);
      finish_op(idx, ea, eb, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
